// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// IF looks up the table combinationally every cycle. ID reports resolved control
// transfers back, and the block raises a redirect when the carried prediction was wrong.
module branch_target_buffer #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned STAT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [1:0]        upd_kind,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   input  logic              flush_all,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] stat_lookups,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

   localparam logic [1:0] KIND_COND = 2'b00;
   localparam logic [1:0] KIND_JUMP = 2'b01;
   localparam logic [1:0] KIND_IND  = 2'b10;
   localparam logic [1:0] KIND_RSVD = 2'b11;

   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_kind_jump;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [ADDR_W-1:0]  r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];
   logic [STAT_W-1:0]  r_stat_lookups;
   logic [STAT_W-1:0]  r_stat_mispred;

   logic [IDX_W-1:0]   w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;
   logic [IDX_W-1:0]   w_upd_idx;
   logic [TAG_W-1:0]   w_upd_tag;
   logic               w_upd_hit;
   logic               w_redirect;

   // Lookup and redirect decision, both purely combinational.
   always_comb begin
      w_if_idx    = if_pc[IDX_W+1:2];
      w_if_tag    = if_pc[ADDR_W-1:IDX_W+2];
      w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      pred_taken  = w_if_hit && (r_kind_jump[w_if_idx] || r_ctr[w_if_idx][1]);
      pred_target = pred_taken ? r_target[w_if_idx] : if_pc + PC_INC;

      w_upd_idx   = upd_pc[IDX_W+1:2];
      w_upd_tag   = upd_pc[ADDR_W-1:IDX_W+2];
      w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

      w_redirect  = upd_valid && (upd_kind != KIND_RSVD) &&
                    ((upd_pred_taken != upd_taken) ||
                     (upd_taken && (upd_pred_target != upd_target)));
      redirect_valid = w_redirect;
      redirect_pc    = upd_taken ? upd_target : upd_pc + PC_INC;
      stat_lookups   = r_stat_lookups;
      stat_mispred   = r_stat_mispred;
   end

   // Table update: flush wins over any same-cycle update; indirect hits are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid     <= '0;
         r_kind_jump <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (flush_all) begin
         r_valid <= '0;
      end else if (upd_valid) begin
         case (upd_kind)
            KIND_COND, KIND_JUMP: begin
               if (w_upd_hit) begin
                  if (upd_taken) begin
                     r_target[w_upd_idx] <= upd_target;
                  end
                  if (upd_kind == KIND_COND) begin
                     if (upd_taken && (r_ctr[w_upd_idx] != 2'b11)) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
                     end else if (!upd_taken && (r_ctr[w_upd_idx] != 2'b00)) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
                     end
                  end
               end else if (upd_taken) begin
                  r_valid[w_upd_idx]     <= 1'b1;
                  r_kind_jump[w_upd_idx] <= (upd_kind == KIND_JUMP);
                  r_tag[w_upd_idx]       <= w_upd_tag;
                  r_target[w_upd_idx]    <= upd_target;
                  r_ctr[w_upd_idx]       <= 2'b10;
               end
            end
            KIND_IND: begin
               // Keep jr/jalr resolving in ID: never leave a predicting alias behind.
               if (w_upd_hit) begin
                  r_valid[w_upd_idx] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Saturating statistics counters; cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_lookups <= '0;
         r_stat_mispred <= '0;
      end else begin
         if (if_valid && !(&r_stat_lookups)) begin
            r_stat_lookups <= r_stat_lookups + STAT_W'(1);
         end
         if (w_redirect && !(&r_stat_mispred)) begin
            r_stat_mispred <= r_stat_mispred + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16, ADDR_W=32, STAT_W=4).
module tb_branch_target_buffer;

   logic        clk;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [1:0]  upd_kind;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        flush_all;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [3:0]  stat_lookups;
   logic [3:0]  stat_mispred;

   int checks;
   int failures;

   branch_target_buffer #(
      .ENTRIES (16),
      .ADDR_W  (32),
      .STAT_W  (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_kind        (upd_kind),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .flush_all       (flush_all),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .stat_lookups    (stat_lookups),
      .stat_mispred    (stat_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic [1:0] kind, input logic taken,
                          input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_kind        = kind;
      upd_taken       = taken;
      upd_target      = tgt;
      upd_pred_taken  = ptaken;
      upd_pred_target = ptgt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      if_pc = 32'h8000_0010;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++; $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken);
      end
      checks++;
      if (pred_target !== 32'h8000_0014) begin
         failures++; $display("FAIL reset_pred_target got=%h exp=80000014", pred_target);
      end
      checks++;
      if (redirect_valid !== 1'b0) begin
         failures++; $display("FAIL reset_redirect got=%0b exp=0", redirect_valid);
      end
      checks++;
      if (stat_lookups !== 4'd0 || stat_mispred !== 4'd0) begin
         failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_lookups, stat_mispred);
      end
   endtask

   task automatic test_alloc();
      set_upd(32'h8000_0020, 2'b00, 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0024);
      if_pc = 32'h8000_0020;
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000) begin
         failures++;
         $display("FAIL alloc_redirect got=%0b/%h exp=1/80000000", redirect_valid, redirect_pc);
      end
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++; $display("FAIL read_before_write got=%0b exp=0", pred_taken);
      end
      step();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h8000_0000) begin
         failures++;
         $display("FAIL alloc_lookup got=%0b/%h exp=1/80000000", pred_taken, pred_target);
      end
      checks++;
      if (stat_mispred !== 4'd1) begin
         failures++; $display("FAIL alloc_mispred_stat got=%0d exp=1", stat_mispred);
      end
   endtask

   task automatic test_counter();
      // ctr starts at 10: NT NT NT T T T T NT NT -> 01 00 00 01 10 11 11 10 01
      logic [8:0] tk;
      logic [8:0] exp_pred;
      tk       = 9'b001111000;
      exp_pred = 9'b011110000;
      if_pc = 32'h8000_0020;
      for (int i = 0; i < 9; i++) begin
         set_upd(32'h8000_0020, 2'b00, tk[i], 32'h8000_0000, tk[i],
                 tk[i] ? 32'h8000_0000 : 32'h8000_0024);
         #1;
         checks++;
         if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL ctr_no_redirect step=%0d got=%0b exp=0", i, redirect_valid);
         end
         step();
         upd_valid = 1'b0;
         #1;
         checks++;
         if (pred_taken !== exp_pred[i]) begin
            failures++;
            $display("FAIL ctr_pred step=%0d got=%0b exp=%0b", i, pred_taken, exp_pred[i]);
         end
      end
      checks++;
      if (stat_mispred !== 4'd1) begin
         failures++; $display("FAIL ctr_mispred_stat got=%0d exp=1", stat_mispred);
      end
   endtask

   task automatic test_redirect();
      // Right direction, wrong target.
      set_upd(32'h8000_0030, 2'b00, 1'b1, 32'h8000_0400, 1'b1, 32'h8000_0000);
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0400) begin
         failures++;
         $display("FAIL redir_target got=%0b/%h exp=1/80000400", redirect_valid, redirect_pc);
      end
      // Predicted taken, actually not taken, at the top of the address space.
      set_upd(32'hFFFF_FFFC, 2'b00, 1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000);
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0000) begin
         failures++;
         $display("FAIL redir_wrap got=%0b/%h exp=1/00000000", redirect_valid, redirect_pc);
      end
      // Reserved kind never redirects.
      set_upd(32'h8000_0030, 2'b11, 1'b1, 32'h8000_0400, 1'b0, 32'h8000_0034);
      #1;
      checks++;
      if (redirect_valid !== 1'b0) begin
         failures++; $display("FAIL redir_reserved got=%0b exp=0", redirect_valid);
      end
      upd_valid = 1'b0;
      if_pc = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0000) begin
         failures++;
         $display("FAIL lookup_wrap got=%0b/%h exp=0/00000000", pred_taken, pred_target);
      end
   endtask

   task automatic test_evict();
      set_upd(32'h8000_0040, 2'b01, 1'b1, 32'h8000_2000, 1'b0, 32'h8000_0044);
      step();
      upd_valid = 1'b0;
      if_pc = 32'h8000_0040;
      #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h8000_2000) begin
         failures++;
         $display("FAIL jump_alloc got=%0b/%h exp=1/80002000", pred_taken, pred_target);
      end
      set_upd(32'h8000_0080, 2'b00, 1'b1, 32'h8000_3000, 1'b0, 32'h8000_0084);
      step();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h8000_0044) begin
         failures++;
         $display("FAIL evicted_lookup got=%0b/%h exp=0/80000044", pred_taken, pred_target);
      end
      if_pc = 32'h8000_0080;
      #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h8000_3000) begin
         failures++;
         $display("FAIL evictor_lookup got=%0b/%h exp=1/80003000", pred_taken, pred_target);
      end
   endtask

   task automatic test_indirect_flush();
      // jr aliasing a live entry invalidates it.
      set_upd(32'h8000_0080, 2'b10, 1'b1, 32'h8000_5000, 1'b1, 32'h8000_3000);
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_5000) begin
         failures++;
         $display("FAIL jr_alias_redirect got=%0b/%h exp=1/80005000", redirect_valid, redirect_pc);
      end
      step();
      upd_valid = 1'b0;
      if_pc = 32'h8000_0080;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++; $display("FAIL jr_alias_invalidate got=%0b exp=0", pred_taken);
      end
      set_upd(32'h8000_0100, 2'b10, 1'b1, 32'h8000_1000, 1'b0, 32'h8000_0104);
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_1000) begin
         failures++;
         $display("FAIL jr_redirect got=%0b/%h exp=1/80001000", redirect_valid, redirect_pc);
      end
      step();
      upd_valid = 1'b0;
      if_pc = 32'h8000_0100;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h8000_0104) begin
         failures++;
         $display("FAIL jr_no_alloc got=%0b/%h exp=0/80000104", pred_taken, pred_target);
      end
      // Correctly predicted jump allocates a live entry for the flush to clear.
      set_upd(32'h8000_0300, 2'b01, 1'b1, 32'h8000_0500, 1'b1, 32'h8000_0500);
      step();
      set_upd(32'h8000_0200, 2'b01, 1'b1, 32'h8000_0700, 1'b0, 32'h8000_0204);
      flush_all = 1'b1;
      if_pc = 32'h8000_0300;
      #1;
      checks++;
      if (pred_taken !== 1'b1) begin
         failures++; $display("FAIL pre_flush_hit got=%0b exp=1", pred_taken);
      end
      step();
      upd_valid = 1'b0;
      flush_all = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++; $display("FAIL flush_clears got=%0b exp=0", pred_taken);
      end
      if_pc = 32'h8000_0200;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++; $display("FAIL flush_blocks_alloc got=%0b exp=0", pred_taken);
      end
      checks++;
      if (stat_mispred !== 4'd6) begin
         failures++; $display("FAIL mispred_count got=%0d exp=6", stat_mispred);
      end
   endtask

   task automatic test_stats_reset();
      checks++;
      if (stat_lookups !== 4'd0) begin
         failures++; $display("FAIL lookups_idle got=%0d exp=0", stat_lookups);
      end
      if_valid = 1'b1;
      for (int i = 0; i < 20; i++) step();
      if_valid = 1'b0;
      checks++;
      if (stat_lookups !== 4'd15) begin
         failures++; $display("FAIL lookups_saturate got=%0d exp=15", stat_lookups);
      end
      set_upd(32'h8000_0040, 2'b01, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_2000);
      step();
      if_pc = 32'h8000_0040;
      set_upd(32'h8000_0600, 2'b00, 1'b1, 32'h8000_0900, 1'b0, 32'h8000_0604);
      #2;
      checks++;
      if (pred_taken !== 1'b1) begin
         failures++; $display("FAIL pre_reset_hit got=%0b exp=1", pred_taken);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || stat_lookups !== 4'd0 || stat_mispred !== 4'd0) begin
         failures++;
         $display("FAIL async_reset got=%0b/%0d/%0d exp=0/0/0", pred_taken, stat_lookups,
                  stat_mispred);
      end
      step();
      reset = 1'b0;
      upd_valid = 1'b0;
      if_pc = 32'h8000_0600;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h8000_0604) begin
         failures++;
         $display("FAIL reset_blocks_alloc got=%0b/%h exp=0/80000604", pred_taken, pred_target);
      end
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      if_valid        = 1'b0;
      if_pc           = '0;
      upd_valid       = 1'b0;
      upd_pc          = '0;
      upd_kind        = 2'b00;
      upd_taken       = 1'b0;
      upd_target      = '0;
      upd_pred_taken  = 1'b0;
      upd_pred_target = '0;
      flush_all       = 1'b0;
      test_reset();
      test_alloc();
      test_counter();
      test_redirect();
      test_evict();
      test_indirect_flush();
      test_stats_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
